// File: rtl/pulse_driver.sv
// Turns one-cycle event requests into timing-qualified output pulses.
// Each pulse is high for HIGH_CYCLES, then low for at least LOW_CYCLES; extra events are queued.
module pulse_driver #(
    parameter int HIGH_CYCLES = 100,
    parameter int LOW_CYCLES  = 100,
    parameter int PW          = 4,
    parameter int CW          = $clog2(((HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES) + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          trigger,
    input  logic          ovf_clr,
    output logic          pulse_out,
    output logic          busy,
    output logic [PW-1:0] pending,
    output logic          overflow
);

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        GAP
    } state_e;

    localparam logic [CW-1:0] HIGH_LAST = CW'(HIGH_CYCLES - 1);
    localparam logic [CW-1:0] LOW_LAST  = CW'(LOW_CYCLES - 1);
    localparam logic [PW-1:0] PEND_MAX  = '1;

    state_e        state_q, state_d;
    logic [CW-1:0] timer_q, timer_d;
    logic [PW-1:0] pending_q, pending_d;
    logic          overflow_q, overflow_d;
    logic          pulse_q, pulse_d;

    logic gap_end;
    logic dequeue;
    logic direct_restart;
    logic queue_req;
    logic drop;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
            pulse_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            pulse_q    <= pulse_d;
        end
    end

    // A trigger in the final gap cycle with nothing queued restarts directly
    // rather than passing through the queue, so IDLE never holds a pending event.
    always_comb begin
        gap_end        = (state_q == GAP) && (timer_q == LOW_LAST);
        dequeue        = gap_end && (pending_q != '0);
        direct_restart = gap_end && (pending_q == '0) && trigger;
        queue_req      = trigger && (state_q != IDLE) && !direct_restart;
        drop           = queue_req && (pending_q == PEND_MAX) && !dequeue;
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;

        case (state_q)
            IDLE: begin
                if (trigger) begin
                    state_d = HIGH;
                    timer_d = '0;
                end
            end
            HIGH: begin
                if (timer_q == HIGH_LAST) begin
                    state_d = GAP;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            GAP: begin
                if (gap_end) begin
                    timer_d = '0;
                    if (dequeue || direct_restart) begin
                        state_d = HIGH;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    // An accepted enqueue and a dequeue in the same cycle cancel out.
    always_comb begin
        pending_d = pending_q;
        case ({queue_req && !drop, dequeue})
            2'b10:   pending_d = pending_q + 1'b1;
            2'b01:   pending_d = pending_q - 1'b1;
            default: pending_d = pending_q;
        endcase
    end

    always_comb begin
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end
    end

    // The pin is driven straight from a flop that mirrors the next state.
    always_comb begin
        pulse_d = (state_d == HIGH);
    end

    assign pulse_out = pulse_q;
    assign busy      = (state_q != IDLE);
    assign pending   = pending_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_pulse_driver.sv
// Directed-vector bench for pulse_driver with HIGH_CYCLES=4, LOW_CYCLES=3, PW=2.
// Each scenario gives per-cycle input masks and hand-derived per-cycle output masks.
module tb_pulse_driver;

    logic       clk;
    logic       reset;
    logic       trigger;
    logic       ovf_clr;
    logic       pulse_out;
    logic       busy;
    logic [1:0] pending;
    logic       overflow;

    int compared;
    int mismatched;

    pulse_driver #(
        .HIGH_CYCLES(4),
        .LOW_CYCLES (3),
        .PW         (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .trigger  (trigger),
        .ovf_clr  (ovf_clr),
        .pulse_out(pulse_out),
        .busy     (busy),
        .pending  (pending),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] rng(input int a, input int b);
        logic [63:0] m;
        m = '0;
        for (int i = a; i <= b; i++) m[i] = 1'b1;
        return m;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Cycle c: inputs set at the negedge inside c are sampled by the posedge ending c;
    // outputs read at that negedge reflect the posedge that began c.
    task automatic applyStimulus(
        input int          id,
        input int          n,
        input logic [63:0] trig,
        input logic [63:0] rst,
        input logic [63:0] clr,
        input logic [63:0] exp_pulse,
        input logic [63:0] exp_busy,
        input logic [63:0] exp_p0,
        input logic [63:0] exp_p1,
        input logic [63:0] exp_ovf
    );
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (c >= 1) begin
                checkOutput($sformatf("s%0d.c%0d.pulse_out", id, c), 32'(pulse_out), 32'(exp_pulse[c]));
                checkOutput($sformatf("s%0d.c%0d.busy", id, c), 32'(busy), 32'(exp_busy[c]));
                checkOutput($sformatf("s%0d.c%0d.pending", id, c), 32'(pending), 32'({exp_p1[c], exp_p0[c]}));
                checkOutput($sformatf("s%0d.c%0d.overflow", id, c), 32'(overflow), 32'(exp_ovf[c]));
            end
            reset   = rst[c];
            trigger = trig[c];
            ovf_clr = clr[c];
        end
        reset   = 1'b0;
        trigger = 1'b0;
        ovf_clr = 1'b0;
    endtask

    initial begin
        logic [63:0] rst_base;
        compared   = 0;
        mismatched = 0;
        reset      = 1'b1;
        trigger    = 1'b0;
        ovf_clr    = 1'b0;
        rst_base   = rng(0, 2);

        // Single trigger.
        applyStimulus(1, 40, rng(10, 10), rst_base, '0,
                      rng(11, 14), rng(11, 17), '0, '0, '0);

        // Three back-to-back triggers replayed in order.
        applyStimulus(2, 40, rng(10, 12), rst_base, '0,
                      rng(11, 14) | rng(18, 21) | rng(25, 28), rng(11, 31),
                      rng(12, 12) | rng(18, 24), rng(13, 17), '0);

        // Saturation: triggers at 14 and 15 dropped, overflow cleared at 40.
        applyStimulus(3, 45, rng(10, 15), rst_base, rng(40, 40),
                      rng(11, 14) | rng(18, 21) | rng(25, 28) | rng(32, 35), rng(11, 38),
                      rng(12, 12) | rng(14, 17) | rng(25, 31), rng(13, 24), rng(15, 40));

        // Reset mid-pulse with one event queued, then a fresh trigger.
        applyStimulus(4, 30, rng(10, 11) | rng(16, 16), rst_base | rng(12, 12), '0,
                      rng(11, 12) | rng(17, 20), rng(11, 12) | rng(17, 23),
                      rng(12, 12), '0, '0);

        // Trigger colliding with the dequeue in the last gap cycle.
        applyStimulus(5, 40, rng(10, 11) | rng(17, 17), rst_base, '0,
                      rng(11, 14) | rng(18, 21) | rng(25, 28), rng(11, 31),
                      rng(12, 24), '0, '0);

        // Trigger in the last gap cycle with an empty queue restarts directly.
        applyStimulus(6, 30, rng(10, 10) | rng(17, 17), rst_base, '0,
                      rng(11, 14) | rng(18, 21), rng(11, 24), '0, '0, '0);

        // Set beats clear when a drop and ovf_clr coincide; clear alone then wins.
        applyStimulus(7, 45, rng(10, 15), rst_base, rng(15, 16),
                      rng(11, 14) | rng(18, 21) | rng(25, 28) | rng(32, 35), rng(11, 38),
                      rng(12, 12) | rng(14, 17) | rng(25, 31), rng(13, 24), rng(15, 16));

        // A trigger while saturated is accepted when a dequeue happens that cycle.
        applyStimulus(8, 50, rng(10, 13) | rng(17, 17), rst_base, '0,
                      rng(11, 14) | rng(18, 21) | rng(25, 28) | rng(32, 35) | rng(39, 42),
                      rng(11, 45),
                      rng(12, 12) | rng(14, 24) | rng(32, 38), rng(13, 31), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
